// File: rtl/mul_pipe_unit_pkg.sv
// Shared definitions for the multi-cycle multiply unit: op encodings,
// pipeline depth bounds and the hard-wired zero register.
package mul_pipe_unit_pkg;

   typedef enum logic [1:0] {
      OP_MUL    = 2'd0,
      OP_MULH   = 2'd1,
      OP_MULHSU = 2'd2,
      OP_MULHU  = 2'd3
   } mul_op_e;

   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 8;
   localparam int ZERO_REG    = 0;

   // Operand A is signed for MULH and MULHSU; operand B only for MULH.
   function automatic logic op_a_signed(input logic [1:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU);
   endfunction

   function automatic logic op_b_signed(input logic [1:0] op);
      return (op == OP_MULH);
   endfunction

endpackage

// File: rtl/mul_pipe_unit_if.sv
// Issue/result bus of the multiply unit: the execute stage is the master,
// the unit is the slave.
interface mul_pipe_unit_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);

   logic              in_valid;
   logic [1:0]        in_op;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [REG_W-1:0]  in_dst_reg;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_result;
   logic [REG_W-1:0]  out_dst_reg;

   modport master (
      output in_valid, in_op, in_a, in_b, in_dst_reg,
      input  in_ready, out_valid, out_result, out_dst_reg
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_dst_reg,
      output in_ready, out_valid, out_result, out_dst_reg
   );

endinterface

// File: rtl/mul_pipe_unit_stage.sv
// One register slice of the multiply pipe: valid bit, destination register
// and payload, with hold on stall and valid clear on flush.
module mul_pipe_stage #(
   parameter int REG_W  = 5,
   parameter int DATA_W = 66
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [REG_W-1:0]  in_dst,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [REG_W-1:0]  out_dst,
   output logic [DATA_W-1:0] out_data
);

   // Flush only kills the valid bit; stale payload is harmless once invalid.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_dst   <= '0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (!stall) begin
         out_valid <= in_valid;
         out_dst   <= in_dst;
         out_data  <= in_data;
      end
   end

endmodule

// File: rtl/mul_pipe_unit.sv
// Pipelined multiply unit for the execute stage, with in-flight register
// lookups so hazard detection can stall or bypass against pending results.
module mul_pipe_unit
   import mul_pipe_unit_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int LATENCY = 3,
   parameter int REG_W   = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   mul_pipe_unit_if.slave   bus,
   output logic             busy,
   input  logic [REG_W-1:0] q_reg_1,
   input  logic [REG_W-1:0] q_reg_2,
   output logic             q_pending_1,
   output logic             q_pending_2,
   output logic             q_fwd_1,
   output logic             q_fwd_2
);

   localparam int PROD_W  = 2 * DATA_W;
   localparam int STAGE_W = PROD_W + 2;
   localparam int LAST    = LATENCY - 1;

   logic              a_sign;
   logic              b_sign;
   logic [PROD_W-1:0] a_wide;
   logic [PROD_W-1:0] b_wide;
   logic [PROD_W-1:0] product;

   logic [LATENCY-1:0] stage_valid;
   logic [REG_W-1:0]   stage_dst  [LATENCY];
   logic [STAGE_W-1:0] stage_data [LATENCY];

   logic [1:0]        final_op;
   logic [PROD_W-1:0] final_prod;

   // Extending straight to 2*DATA_W gives the same low 2*DATA_W product bits
   // as a DATA_W+1 signed multiply, which is all either half-select needs.
   always_comb begin
      a_sign  = op_a_signed(bus.in_op) & bus.in_a[DATA_W-1];
      b_sign  = op_b_signed(bus.in_op) & bus.in_b[DATA_W-1];
      a_wide  = {{DATA_W{a_sign}}, bus.in_a};
      b_wide  = {{DATA_W{b_sign}}, bus.in_b};
      product = a_wide * b_wide;
   end

   generate
      for (genvar k = 0; k < LATENCY; k++) begin : g_stage
         if (k == 0) begin : g_head
            mul_pipe_stage #(
               .REG_W  (REG_W),
               .DATA_W (STAGE_W)
            ) u_stage (
               .clock     (clock),
               .reset     (reset),
               .stall     (stall),
               .flush     (flush),
               .in_valid  (bus.in_valid),
               .in_dst    (bus.in_dst_reg),
               .in_data   ({bus.in_op, product}),
               .out_valid (stage_valid[k]),
               .out_dst   (stage_dst[k]),
               .out_data  (stage_data[k])
            );
         end else begin : g_body
            mul_pipe_stage #(
               .REG_W  (REG_W),
               .DATA_W (STAGE_W)
            ) u_stage (
               .clock     (clock),
               .reset     (reset),
               .stall     (stall),
               .flush     (flush),
               .in_valid  (stage_valid[k-1]),
               .in_dst    (stage_dst[k-1]),
               .in_data   (stage_data[k-1]),
               .out_valid (stage_valid[k]),
               .out_dst   (stage_dst[k]),
               .out_data  (stage_data[k])
            );
         end
      end
   endgenerate

   always_comb begin
      final_op   = stage_data[LAST][STAGE_W-1 -: 2];
      final_prod = stage_data[LAST][PROD_W-1:0];
   end

   assign bus.in_ready    = ~stall & ~flush;
   assign bus.out_valid   = stage_valid[LAST];
   assign bus.out_dst_reg = stage_dst[LAST];
   assign bus.out_result  = (final_op == OP_MUL) ? final_prod[DATA_W-1:0]
                                                 : final_prod[PROD_W-1:DATA_W];
   assign busy            = |stage_valid;

   // Any younger writer still in flight shadows the final stage, so the
   // bypass is only offered when nothing newer is pending.
   always_comb begin
      q_pending_1 = 1'b0;
      q_pending_2 = 1'b0;
      for (int k = 0; k < LAST; k++) begin
         if (stage_valid[k] && stage_dst[k] != REG_W'(ZERO_REG)) begin
            if (stage_dst[k] == q_reg_1) q_pending_1 = 1'b1;
            if (stage_dst[k] == q_reg_2) q_pending_2 = 1'b1;
         end
      end
      q_fwd_1 = stage_valid[LAST] && stage_dst[LAST] != REG_W'(ZERO_REG)
                && stage_dst[LAST] == q_reg_1 && !q_pending_1;
      q_fwd_2 = stage_valid[LAST] && stage_dst[LAST] != REG_W'(ZERO_REG)
                && stage_dst[LAST] == q_reg_2 && !q_pending_2;
   end

endmodule
